regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//  Parametrised successor to the Y86 register file: WIDTH-bit x NUM_REGS registers, two async read ports
//  (srcA/srcB) and two sync write ports (dstE/dstM). Adds a sequential reset-clear engine, a ready
//  flag, defined out-of-range/RNONE handling and a sticky error flag.
//  Sits between decode (reads) and writeback (writes) in the pipeline.
// PARAMETERS
//  WIDTH       32     data width of each register and of valE/valM/valA/valB
//  NUM_REGS    8      number of registers, 1..15 (index 4'hF is always RNONE)
//  INIT_VALUE  0      value written into every register by the clear engine
// PORTS
//  clk     in   1      clock, all state updates on posedge
//  rst     in   1      synchronous, active-high reset
//  srcA    in   4      read index A; `RNONE = no read
//  srcB    in   4      read index B; `RNONE = no read
//  dstE    in   4      write index E; `RNONE = no write
//  dstM    in   4      write index M; `RNONE = no write
//  valE    in   WIDTH  write data E
//  valM    in   WIDTH  write data M
//  valA    out  WIDTH  read data A (combinational)
//  valB    out  WIDTH  read data B (combinational)
//  ready   out  1      1 = clear finished, writes accepted
//  err     out  1      sticky: write attempted to index in [NUM_REGS..14]
// BEHAVIOUR
//  - FSM states: INIT, RUN. rst (any cycle, incl. mid-INIT) -> INIT, clear counter=0, err=0, ready=0.
//  - INIT: each cycle regs[cnt] <= INIT_VALUE, cnt++; at cnt==NUM_REGS-1 next state RUN.
//    Clear takes exactly NUM_REGS cycles after rst deasserts; ready=1 from the following cycle.
//  - INIT: dstE/dstM writes ignored (not queued); valA=valB=0; err is not set.
//  - RUN: posedge write regs[dstE]<=valE, regs[dstM]<=valM when index valid.
//  - dstE==dstM (valid): valM wins; valE is dropped.
//  - Index valid = idx < NUM_REGS. idx==`RNONE: no-op. idx in [NUM_REGS..14]: write dropped, err<=1
//    (held until rst).
//  - Read: src==`RNONE or src>=NUM_REGS -> 0. Otherwise regs[src]. No latches: output always driven.
//  - Reads see register contents as of the last posedge unless bypass (below) is compiled in.
//  - Reset values: ready=0, err=0, valA=valB=0, all regs INIT_VALUE after clear.
//  - Latency: write->visible on read = 1 cycle (0 with bypass).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: in RUN, if srcX matches a valid dstM/dstE being written this cycle,
//    valX returns the incoming data combinationally (valM before valE, matching write priority).
//  Undefined: no bypass; the same-cycle read returns the old value.
// STRUCTURE
//  - defines.v: `NIBBLE, `WORD, `RNONE (4'hF), `REGNUM default; add FSM state encodings
//    `RF_INIT / `RF_RUN there.
//  - One sub-module: regfile_clear_ctrl (FSM + counter; outputs clr_we, clr_idx, ready).
//    Array, write-priority, read muxes and bypass stay in regfile_param.
// TESTING
//  1 rst 1 cycle, NUM_REGS=8, INIT_VALUE=32'hA5A5A5A5 -> ready rises exactly 8 cycles after rst
//    drops; srcA=0..7 all read A5A5A5A5.
//  2 RUN: dstE=3 valE=32'h11, dstM=3 valM=32'h22 same cycle -> next cycle srcA=3 reads 32'h22.
//  3 RUN: dstE=9 (NUM_REGS=8) -> no register changes, err=1 and stays 1; rst -> err=0.
//  4 srcA=`RNONE, srcB=12 -> valA=0, valB=0.
//  5 Bypass: dstM=5 valM=32'hDEAD, srcB=5 same cycle -> valB=DEAD with REGFILE_BYPASS_EN,
//    old value without it.
//  6 rst asserted at clear cycle 4, released -> full 8-cycle clear restarts; writes during INIT lost.

Source files
------------

// File: rtl/regfile_param_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_param_pkg;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  // Index width for an array of n entries; a single-entry file still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every register index once, then raises ready.
// The walk takes NUM_REGS cycles after reset drops; reset at any time restarts it from index 0.
module regfile_clear_ctrl
  import regfile_param_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [IW-1:0] clr_idx,
  output logic          ready
);

  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  rf_state_t     state;
  rf_state_t     state_nxt;
  logic [IW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == RF_INIT) begin
        cnt <= (cnt == LAST) ? '0 : cnt + IW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == RF_INIT && cnt == LAST) begin
      state_nxt = RF_RUN;
    end
  end

  always_comb begin
    clr_we  = (state == RF_INIT) && !rst;
    clr_idx = cnt;
    ready   = (state == RF_RUN);
  end

endmodule

// File: rtl/regfile_param.sv
// WIDTH x NUM_REGS register file: two async read ports, two sync write ports (M beats E), sticky err.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               NUM_REGS   = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             ready,
  output logic             err
);

  localparam int         IW   = idx_w(NUM_REGS);
  localparam logic [3:0] NREG = 4'(NUM_REGS);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             clr_we;
  logic [IW-1:0]    clr_idx;
  logic             run_we;
  logic             valid_e, valid_m;
  logic             bad_e, bad_m;
  logic             we_e, we_m;

  regfile_clear_ctrl #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_clear_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  always_comb begin
    run_we  = ready && !rst;
    valid_e = (dstE < NREG);
    valid_m = (dstM < NREG);
    bad_e   = !valid_e && (dstE != RNONE);
    bad_m   = !valid_m && (dstM != RNONE);
    we_e    = run_we && valid_e;
    we_m    = run_we && valid_m;
  end

  // M is written after E so a shared index keeps valM.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_idx] <= INIT_VALUE;
    end else begin
      if (we_e) regs[dstE[IW-1:0]] <= valE;
      if (we_m) regs[dstM[IW-1:0]] <= valM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (run_we && (bad_e || bad_m)) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    valA = '0;
    if (ready && srcA < NREG) begin
      valA = regs[srcA[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
      if (we_e && dstE == srcA) valA = valE;
      if (we_m && dstM == srcA) valA = valM;
`endif
    end
  end

  always_comb begin
    valB = '0;
    if (ready && srcB < NREG) begin
      valB = regs[srcB[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
      if (we_e && dstE == srcB) valB = valE;
      if (we_m && dstM == srcB) valB = valM;
`endif
    end
  end

endmodule
